// File: rtl/spi_apb_bridge_if.sv
// APB-side bus of the SPI-to-APB bridge; master modport faces the bridge.
// SPI2APB_PSLVERR_EN adds the b_pslverr slave response line.
interface spi_apb_bridge_if #(
  parameter int BANK_NUM   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic                  b_pclk;
  logic                  b_presetn;
  logic [BANK_NUM-1:0]   b_psel;
  logic                  b_penable;
  logic                  b_pwrite;
  logic [ADDR_WIDTH-1:0] b_paddr;
  logic [DATA_WIDTH-1:0] b_pwdata;
  logic [DATA_WIDTH-1:0] b_prdata;
  logic                  b_pready;
`ifdef SPI2APB_PSLVERR_EN
  logic                  b_pslverr;
`endif

  modport master (
    output b_pclk, b_presetn, b_psel, b_penable, b_pwrite, b_paddr, b_pwdata,
    input  b_prdata, b_pready
`ifdef SPI2APB_PSLVERR_EN
    , input b_pslverr
`endif
  );

  modport slave (
    input  b_pclk, b_presetn, b_psel, b_penable, b_pwrite, b_paddr, b_pwdata,
    output b_prdata, b_pready
`ifdef SPI2APB_PSLVERR_EN
    , output b_pslverr
`endif
  );
endinterface

// File: rtl/spi_apb_bridge.sv
// SPI slave (mode 0, MSB first) to APB master; one SPI frame = one APB transfer, all on sclk.
// Optional SPI2APB_PSLVERR_EN: sticky spi_err output fed by b_pslverr.
module spi_apb_bridge #(
  parameter int BANK_NUM   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic sclk,
  input  logic resetn,
  input  logic ss,
  input  logic mosi,
  output logic miso,
  spi_apb_bridge_if.master bus
`ifdef SPI2APB_PSLVERR_EN
  , output logic spi_err
`endif
);
  localparam int BW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam int CW = $clog2((DATA_WIDTH > 8) ? DATA_WIDTH : 8);
  localparam int TW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_WDATA  = 3'd2;
  localparam logic [2:0] S_SETUP  = 3'd3;
  localparam logic [2:0] S_ACCESS = 3'd4;
  localparam logic [2:0] S_SEND   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]            state;
  logic [6:0]            hdr;
  logic [7:0]            hdr_nxt;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] sr;
  logic [BW-1:0]         bank;
  logic [BANK_NUM-1:0]   sel_dec;
  logic                  apb_done;
  logic [TW-1:0]         tx_idx;

  assign bus.b_pclk    = sclk;
  assign bus.b_presetn = ~resetn;

  // Reads decode on the 8th edge from the bit still arriving; writes use the stored header.
  assign hdr_nxt = {hdr, mosi};
  assign bank    = (state == S_HDR) ? hdr_nxt[ADDR_WIDTH +: BW] : hdr[ADDR_WIDTH +: BW];

  always_comb begin
    sel_dec = '0;
    for (int unsigned i = 0; i < BANK_NUM; i++)
      sel_dec[i] = (bank == BW'(i));
  end

  // An out-of-range bank leaves psel clear and completes without waiting on the bus.
  assign apb_done = (bus.b_psel == '0) || bus.b_pready;

  always_ff @(posedge sclk or posedge resetn or posedge ss) begin
    if (resetn) begin
      state         <= S_IDLE;
      cnt           <= '0;
      hdr           <= '0;
      sr            <= '0;
      bus.b_psel    <= '0;
      bus.b_penable <= 1'b0;
      bus.b_pwrite  <= 1'b0;
      bus.b_paddr   <= '0;
      bus.b_pwdata  <= '0;
    end else if (ss) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.b_psel    <= '0;
      bus.b_penable <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          hdr   <= hdr_nxt[6:0];
          cnt   <= CW'(1);
          state <= S_HDR;
        end
        S_HDR: begin
          hdr <= hdr_nxt[6:0];
          if (cnt == CW'(7)) begin
            cnt <= '0;
            if (hdr_nxt[7]) begin
              state <= S_WDATA;
            end else begin
              bus.b_paddr  <= hdr_nxt[ADDR_WIDTH-1:0];
              bus.b_pwrite <= 1'b0;
              bus.b_psel   <= sel_dec;
              state        <= S_SETUP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WDATA: begin
          sr <= {sr[DATA_WIDTH-2:0], mosi};
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            bus.b_pwdata <= {sr[DATA_WIDTH-2:0], mosi};
            bus.b_paddr  <= hdr[ADDR_WIDTH-1:0];
            bus.b_pwrite <= 1'b1;
            bus.b_psel   <= sel_dec;
            state        <= S_SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SETUP: begin
          bus.b_penable <= |bus.b_psel;
          state         <= S_ACCESS;
        end
        S_ACCESS: begin
          if (apb_done) begin
            bus.b_psel    <= '0;
            bus.b_penable <= 1'b0;
            if (!bus.b_pwrite)
              sr <= (|bus.b_psel) ? bus.b_prdata : '0;
            state <= bus.b_pwrite ? S_DONE : S_SEND;
          end
        end
        default: state <= state;
      endcase
    end
  end

  always_ff @(negedge sclk or posedge resetn or posedge ss) begin
    if (resetn || ss) begin
      miso   <= 1'b0;
      tx_idx <= '0;
    end else if (state == S_SEND && tx_idx < TW'(DATA_WIDTH)) begin
      miso   <= sr[DATA_WIDTH - 1 - int'(tx_idx)];
      tx_idx <= tx_idx + 1'b1;
    end else begin
      miso <= 1'b0;
    end
  end

`ifdef SPI2APB_PSLVERR_EN
  // Error is the difference of two toggles: set in the sclk domain, cleared on ss fall.
  logic err_set_tog, err_clr_tog;

  always_ff @(posedge sclk or posedge resetn) begin
    if (resetn)
      err_set_tog <= 1'b0;
    else if (!ss && state == S_ACCESS && apb_done && (|bus.b_psel) && bus.b_pslverr && !spi_err)
      err_set_tog <= ~err_set_tog;
  end

  always_ff @(negedge ss or posedge resetn) begin
    if (resetn)
      err_clr_tog <= 1'b0;
    else
      err_clr_tog <= err_set_tog;
  end

  assign spi_err = err_set_tog ^ err_clr_tog;
`endif
endmodule

// File: tb/tb_spi_apb_bridge.sv
// Randomized bench for spi_apb_bridge: frames are scored against a frame-level model
// derived from header fields, wait-state count and frame timing.
module tb_spi_apb_bridge;
  localparam int BANK_NUM   = 2;
  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;

  logic sclk = 1'b0;
  logic resetn, ss, mosi, miso;
`ifdef SPI2APB_PSLVERR_EN
  logic spi_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] last_wdat;

  spi_apb_bridge_if #(.BANK_NUM(BANK_NUM), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  spi_apb_bridge #(.BANK_NUM(BANK_NUM), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_dut (
    .sclk   (sclk),
    .resetn (resetn),
    .ss     (ss),
    .mosi   (mosi),
    .miso   (miso),
    .bus    (bus)
`ifdef SPI2APB_PSLVERR_EN
    , .spi_err (spi_err)
`endif
  );

  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete frame with the APB slave inserting 'waits' wait states.
  task automatic run_frame(input logic [7:0] hdr, input logic [7:0] wdat, input int waits,
                           input logic [7:0] rdat, input logic err_in);
    logic [15:0] frame;
    logic        rw;
    logic [1:0]  exp_sel, cap_sel;
    logic [2:0]  cap_addr;
    logic        cap_wr;
    logic [7:0]  cap_wd, miso_got;
    int first, last, pen, setup, acc, stray, mi, total;
    frame    = {hdr, wdat};
    rw       = hdr[7];
    exp_sel  = 2'(1 << hdr[3]);
    total    = 19 + waits;
    first    = -1; last = -1; pen = 0; setup = 0; acc = 0; stray = 0;
    miso_got = '0;
    cap_sel  = 'x; cap_addr = 'x; cap_wr = 'x; cap_wd = 'x;
    @(negedge sclk);
    bus.b_prdata = rdat;
    bus.b_pready = 1'b0;
`ifdef SPI2APB_PSLVERR_EN
    bus.b_pslverr = err_in;
`endif
    ss   = 1'b0;
    mosi = frame[15];
`ifdef SPI2APB_PSLVERR_EN
    #1 check("err_clr_on_ss_fall", spi_err, 0);
`endif
    for (int k = 1; k <= total; k++) begin
      @(posedge sclk); #1;
      if (bus.b_psel != '0) begin
        if (first < 0) first = k;
        last = k;
        if (!bus.b_penable) setup++;
      end
      if (bus.b_penable) begin
        pen++;
        cap_sel = bus.b_psel; cap_addr = bus.b_paddr; cap_wr = bus.b_pwrite; cap_wd = bus.b_pwdata;
      end
      mi = k - 11 - waits;
      if (!rw && mi >= 0 && mi < 8) miso_got[7-mi] = miso;
      else if (miso) stray++;
      @(negedge sclk);
      mosi = (k < 16) ? frame[15-k] : 1'($urandom);
      bus.b_pready = bus.b_penable && (acc == waits);
      if (bus.b_penable) acc++;
    end
    if (rw) last_wdat = wdat;
    check("psel", cap_sel, exp_sel);
    check("paddr", cap_addr, hdr[2:0]);
    check("pwrite", cap_wr, rw);
    if (rw) check("pwdata", cap_wd, wdat);
    check("sel_first_edge", first, rw ? 16 : 8);
    check("sel_last_edge", last, (rw ? 17 : 9) + waits);
    check("penable_cycles", pen, waits + 1);
    check("setup_cycles", setup, 1);
    if (!rw) check("miso_data", miso_got, rdat);
    check("miso_stray", stray, 0);
`ifdef SPI2APB_PSLVERR_EN
    check("spi_err", spi_err, err_in);
`endif
    ss = 1'b1;
    #1;
    check("idle_psel", bus.b_psel, 0);
    check("idle_miso", miso, 0);
    check("hold_paddr", bus.b_paddr, hdr[2:0]);
    check("hold_pwrite", bus.b_pwrite, rw);
    check("hold_pwdata", bus.b_pwdata, last_wdat);
`ifdef SPI2APB_PSLVERR_EN
    check("err_sticky", spi_err, err_in);
`endif
  endtask

  initial begin
    logic [15:0] f;
    int stray_sel;
    resetn = 1'b1; ss = 1'b1; mosi = 1'b0;
    bus.b_prdata = '0; bus.b_pready = 1'b0;
`ifdef SPI2APB_PSLVERR_EN
    bus.b_pslverr = 1'b0;
`endif
    last_wdat = '0;
    repeat (3) @(negedge sclk);
    check("rst_psel", bus.b_psel, 0);
    check("rst_penable", bus.b_penable, 0);
    check("rst_pwrite", bus.b_pwrite, 0);
    check("rst_paddr", bus.b_paddr, 0);
    check("rst_pwdata", bus.b_pwdata, 0);
    check("rst_miso", miso, 0);
    check("rst_presetn", bus.b_presetn, 0);
    resetn = 1'b0;
    @(negedge sclk);
    check("run_presetn", bus.b_presetn, 1);

    run_frame(8'hFF, 8'hFF, 0, 8'h00, 1'b0);
    run_frame(8'h55, 8'h00, 0, 8'hF9, 1'b1);
    run_frame(8'h9E, 8'hA5, 3, 8'h00, 1'b0);
    run_frame(8'h22, 8'h00, 3, 8'h6C, 1'b0);

    // Abort after 5 header bits, then a normal write.
    stray_sel = 0;
    f = 16'hFFFF;
    @(negedge sclk); ss = 1'b0; mosi = f[15];
    for (int k = 1; k <= 5; k++) begin
      @(posedge sclk); #1;
      if (bus.b_psel != '0 || bus.b_penable) stray_sel++;
      @(negedge sclk); mosi = f[15-k];
    end
    #2 ss = 1'b1;
    #1 check("abort_no_apb", stray_sel, 0);
    run_frame(8'h8A, 8'h3C, 0, 8'h00, 1'b0);

    for (int n = 0; n < 24; n++)
      run_frame(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 8'($urandom), 1'($urandom));

    // Reset asserted while the transfer is in ACCESS.
    f = 16'hFB77;
    @(negedge sclk); ss = 1'b0; mosi = f[15];
    for (int k = 1; k <= 17; k++) begin
      @(posedge sclk);
      @(negedge sclk);
      if (k < 16) mosi = f[15-k];
    end
    check("pre_rst_penable", bus.b_penable, 1);
    #2 resetn = 1'b1;
    #1;
    check("midrst_psel", bus.b_psel, 0);
    check("midrst_penable", bus.b_penable, 0);
    check("midrst_paddr", bus.b_paddr, 0);
    check("midrst_pwdata", bus.b_pwdata, 0);
    check("midrst_pwrite", bus.b_pwrite, 0);
    check("midrst_presetn", bus.b_presetn, 0);
    @(negedge sclk);
    ss = 1'b1;
    @(negedge sclk);
    resetn = 1'b0;
    last_wdat = '0;
    run_frame(8'h0C, 8'h00, 1, 8'h3A, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
